// File: rtl/rv32_m_issue_if.sv
// Execute-stage <-> M-unit issue bundle: decoded op in, request/response channel, writeback out.
// The master modport is the issue controller's view; the slave modport is the pipeline/M-unit side.
interface rv32_m_issue_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [2:0]      ex_op;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [4:0]      ex_rd;
  logic            flush;
  logic            ex_stall;

  logic            m_req_valid;
  logic            m_req_ready;
  logic [2:0]      m_op;
  logic [XLEN-1:0] m_operand_a;
  logic [XLEN-1:0] m_operand_b;
  logic            m_rsp_valid;
  logic [XLEN-1:0] m_rsp_result;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            timeout_err;

  modport master (
    input  ex_valid, ex_op, ex_rs1, ex_rs2, ex_rd, flush,
    input  m_req_ready, m_rsp_valid, m_rsp_result,
    output ex_stall, m_req_valid, m_op, m_operand_a, m_operand_b,
    output wb_valid, wb_rd, wb_data, timeout_err
  );

  modport slave (
    output ex_valid, ex_op, ex_rs1, ex_rs2, ex_rd, flush,
    output m_req_ready, m_rsp_valid, m_rsp_result,
    input  ex_stall, m_req_valid, m_op, m_operand_a, m_operand_b,
    input  wb_valid, wb_rd, wb_data, timeout_err
  );
endinterface

// File: rtl/rv32_m_issue_ctrl.sv
// M-extension issue controller: latches a decoded op, issues it over valid/ready,
// waits for the result with a timeout, and returns a one-cycle writeback.
//
// state    | meaning
// IDLE     | no op outstanding; stall follows ex_valid && !flush
// REQ      | request presented, operands held until handshake
// WAIT     | request accepted, counting towards timeout
// DRAIN    | op killed or timed out; swallow the late response
// DRAIN_TO | timed out; one-cycle all-ones writeback
// DONE     | result writeback, execute released
module rv32_m_issue_ctrl #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic            clk,
  input logic            rst_n,
  rv32_m_issue_if.master ctrl_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DRAIN_TO, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;

  logic ex_stall, m_req_valid, wb_valid;
  logic accept, hs, rsp, flush, tmo_hit;

  assign flush   = ctrl_if.flush;
  assign rsp     = ctrl_if.m_rsp_valid;
  assign accept  = ctrl_if.ex_valid && !flush;
  assign hs      = ctrl_if.m_req_ready;
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ: begin
        if (hs) begin
          // a flush on the accepting edge cannot recall the op; its response must still be consumed
          if (flush) state_d = rsp ? S_IDLE : S_DRAIN;
          else       state_d = rsp ? S_DONE : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (rsp)          state_d = flush ? S_IDLE : S_DONE;
        else if (flush)   state_d = S_DRAIN;
        else if (tmo_hit) state_d = S_DRAIN_TO;
      end
      S_DRAIN:    if (rsp) state_d = S_IDLE;
      S_DRAIN_TO: state_d = rsp ? S_IDLE : S_DRAIN;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ex_stall    = 1'b0;
    m_req_valid = 1'b0;
    wb_valid    = 1'b0;
    unique case (state_q)
      S_IDLE:     ex_stall = accept;
      S_REQ: begin
        ex_stall    = 1'b1;
        m_req_valid = 1'b1;
      end
      S_WAIT,
      S_DRAIN:    ex_stall = 1'b1;
      S_DRAIN_TO: begin
        ex_stall = 1'b1;
        wb_valid = !flush && (rd_q != 5'd0);
      end
      S_DONE:     wb_valid = !flush && (rd_q != 5'd0);
      default:    ex_stall = 1'b0;
    endcase
  end

  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    rd_d  = rd_q;
    res_d = res_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = ctrl_if.ex_op;
          a_d  = ctrl_if.ex_rs1;
          b_d  = ctrl_if.ex_rs2;
          rd_d = ctrl_if.ex_rd;
        end
      end
      S_REQ: begin
        if (hs) begin
          cnt_d = '0;
          if (rsp && !flush) res_d = ctrl_if.m_rsp_result;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rsp) begin
          if (!flush) res_d = ctrl_if.m_rsp_result;
        end else if (!flush && tmo_hit) begin
          res_d = '1;
          tmo_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      rd_q  <= rd_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign ctrl_if.ex_stall    = ex_stall;
  assign ctrl_if.m_req_valid = m_req_valid;
  assign ctrl_if.m_op        = m_req_valid ? op_q : 3'd0;
  assign ctrl_if.m_operand_a = m_req_valid ? a_q : '0;
  assign ctrl_if.m_operand_b = m_req_valid ? b_q : '0;
  assign ctrl_if.wb_valid    = wb_valid;
  assign ctrl_if.wb_rd       = wb_valid ? rd_q : 5'd0;
  assign ctrl_if.wb_data     = wb_valid ? res_q : '0;
  assign ctrl_if.timeout_err = tmo_q;

endmodule

// File: tb/tb_rv32_m_issue_ctrl.sv
// Directed bench for rv32_m_issue_ctrl (TIMEOUT_CYCLES=4): inputs driven 1ns after posedge,
// outputs compared 2ns after posedge against hand-computed values.
module tb_rv32_m_issue_ctrl;
  localparam int XLEN = 32;
  localparam int TMO  = 4;
  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_REMU = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32_m_issue_if #(.XLEN(XLEN)) bus ();

  rv32_m_issue_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus)
  );

  int chk = 0, pass = 0, hs_cnt = 0, wb_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_req_valid && bus.m_req_ready) hs_cnt++;
      if (bus.wb_valid) wb_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ex_valid = 0; bus.ex_op = 0; bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_rd = 0;
    bus.flush = 0; bus.m_req_ready = 0; bus.m_rsp_valid = 0; bus.m_rsp_result = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.ex_valid = 1; bus.ex_op = op; bus.ex_rs1 = a; bus.ex_rs2 = b; bus.ex_rd = rd;
  endtask

  // same-cycle responder; entered and left with the controller idle
  task automatic run_zero(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res);
    issue(op, a, b, rd);
    #1;
    chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid} !== 3'b100) $display("FAIL zl_c0_flags got %b want 100", {bus.ex_stall, bus.m_req_valid, bus.wb_valid}); else pass++;
    next();
    bus.ex_valid = 0; bus.m_req_ready = 1; bus.m_rsp_valid = 1; bus.m_rsp_result = res;
    #1;
    chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid} !== 3'b110) $display("FAIL zl_c1_flags got %b want 110", {bus.ex_stall, bus.m_req_valid, bus.wb_valid}); else pass++;
    chk++; if ({bus.m_op, bus.m_operand_a, bus.m_operand_b} !== {op, a, b}) $display("FAIL zl_c1_req got %h want %h", {bus.m_op, bus.m_operand_a, bus.m_operand_b}, {op, a, b}); else pass++;
    next();
    bus.m_req_ready = 0; bus.m_rsp_valid = 0; bus.m_rsp_result = 0;
    #1;
    chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid} !== {2'b00, rd != 5'd0}) $display("FAIL zl_c2_flags got %b want %b", {bus.ex_stall, bus.m_req_valid, bus.wb_valid}, {2'b00, rd != 5'd0}); else pass++;
    if (rd != 5'd0) begin
      chk++; if ({bus.wb_rd, bus.wb_data} !== {rd, res}) $display("FAIL zl_c2_wb got %h want %h", {bus.wb_rd, bus.wb_data}, {rd, res}); else pass++;
    end
    next();
    #1;
    chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid} !== 3'b000) $display("FAIL zl_c3_flags got %b want 000", {bus.ex_stall, bus.m_req_valid, bus.wb_valid}); else pass++;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    #12;
    chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid, bus.timeout_err} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {bus.ex_stall, bus.m_req_valid, bus.wb_valid, bus.timeout_err}); else pass++;
    chk++; if ({bus.m_op, bus.m_operand_a, bus.m_operand_b, bus.wb_rd, bus.wb_data} !== 104'b0) $display("FAIL reset_data got %h want 0", {bus.m_op, bus.m_operand_a, bus.m_operand_b, bus.wb_rd, bus.wb_data}); else pass++;
    rst_n = 1;
    next();
  endtask

  task automatic test_zero_latency_mul();
    run_zero(OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42);
  endtask

  task automatic test_backpressure_div();
    int h0, w0;
    h0 = hs_cnt; w0 = wb_cnt;
    issue(OP_DIV, 32'd100, 32'd7, 5'd3);
    bus.m_req_ready = 0;
    next();
    bus.ex_valid = 0; bus.ex_rs1 = 32'hDEAD; bus.ex_rs2 = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk++; if ({bus.m_req_valid, bus.m_op, bus.m_operand_a, bus.m_operand_b} !== {1'b1, OP_DIV, 32'd100, 32'd7}) $display("FAIL bp_hold%0d got %h want %h", i, {bus.m_req_valid, bus.m_op, bus.m_operand_a, bus.m_operand_b}, {1'b1, OP_DIV, 32'd100, 32'd7}); else pass++;
      next();
    end
    bus.m_req_ready = 1;
    #1;
    chk++; if ({bus.ex_stall, bus.m_req_valid} !== 2'b11) $display("FAIL bp_hs got %b want 11", {bus.ex_stall, bus.m_req_valid}); else pass++;
    next();
    bus.m_req_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid} !== 3'b100) $display("FAIL bp_wait%0d got %b want 100", i, {bus.ex_stall, bus.m_req_valid, bus.wb_valid}); else pass++;
      next();
    end
    bus.m_rsp_valid = 1; bus.m_rsp_result = 32'd14;
    #1;
    chk++; if ({bus.ex_stall, bus.wb_valid} !== 2'b10) $display("FAIL bp_rsp got %b want 10", {bus.ex_stall, bus.wb_valid}); else pass++;
    next();
    bus.m_rsp_valid = 0; bus.m_rsp_result = 0;
    #1;
    chk++; if ({bus.ex_stall, bus.wb_valid, bus.wb_rd, bus.wb_data} !== {2'b01, 5'd3, 32'd14}) $display("FAIL bp_wb got %h want %h", {bus.ex_stall, bus.wb_valid, bus.wb_rd, bus.wb_data}, {2'b01, 5'd3, 32'd14}); else pass++;
    next(); next();
    #1;
    chk++; if (hs_cnt - h0 !== 1) $display("FAIL bp_hs_count got %0d want 1", hs_cnt - h0); else pass++;
    chk++; if (wb_cnt - w0 !== 1) $display("FAIL bp_wb_count got %0d want 1", wb_cnt - w0); else pass++;
    drive_idle();
  endtask

  task automatic test_flush_wait();
    int w0;
    w0 = wb_cnt;
    issue(OP_MUL, 32'd3, 32'd4, 5'd9);
    next();
    bus.ex_valid = 0; bus.m_req_ready = 1;
    next();
    bus.m_req_ready = 0; bus.flush = 1;
    #1;
    chk++; if ({bus.ex_stall, bus.wb_valid} !== 2'b10) $display("FAIL fw_flush got %b want 10", {bus.ex_stall, bus.wb_valid}); else pass++;
    next();
    bus.flush = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid} !== 3'b100) $display("FAIL fw_drain%0d got %b want 100", i, {bus.ex_stall, bus.m_req_valid, bus.wb_valid}); else pass++;
      next();
    end
    bus.m_rsp_valid = 1; bus.m_rsp_result = 32'd12;
    #1;
    chk++; if ({bus.ex_stall, bus.wb_valid} !== 2'b10) $display("FAIL fw_late_rsp got %b want 10", {bus.ex_stall, bus.wb_valid}); else pass++;
    next();
    bus.m_rsp_valid = 0; bus.m_rsp_result = 0;
    #1;
    chk++; if ({bus.ex_stall, bus.wb_valid} !== 2'b00) $display("FAIL fw_idle got %b want 00", {bus.ex_stall, bus.wb_valid}); else pass++;
    chk++; if (wb_cnt !== w0) $display("FAIL fw_no_wb got %0d want %0d", wb_cnt, w0); else pass++;
    run_zero(OP_MUL, 32'd5, 32'd5, 5'd1, 32'd25);
  endtask

  task automatic test_flush_edges();
    int w0;
    w0 = wb_cnt;
    issue(OP_MUL, 32'd1, 32'd1, 5'd1);
    bus.flush = 1;
    #1;
    chk++; if (bus.ex_stall !== 1'b0) $display("FAIL fe_idle_stall got %b want 0", bus.ex_stall); else pass++;
    next();
    drive_idle();
    #1;
    chk++; if ({bus.ex_stall, bus.m_req_valid} !== 2'b00) $display("FAIL fe_idle_stay got %b want 00", {bus.ex_stall, bus.m_req_valid}); else pass++;
    issue(OP_MUL, 32'd1, 32'd1, 5'd1);
    next();
    bus.ex_valid = 0; bus.flush = 1;
    #1;
    chk++; if (bus.m_req_valid !== 1'b1) $display("FAIL fe_req_valid got %b want 1", bus.m_req_valid); else pass++;
    next();
    bus.flush = 0;
    #1;
    chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid} !== 3'b000) $display("FAIL fe_req_withdraw got %b want 000", {bus.ex_stall, bus.m_req_valid, bus.wb_valid}); else pass++;
    issue(OP_MUL, 32'd2, 32'd3, 5'd4);
    next();
    bus.ex_valid = 0; bus.m_req_ready = 1; bus.m_rsp_valid = 1; bus.m_rsp_result = 32'd6;
    next();
    bus.m_req_ready = 0; bus.m_rsp_valid = 0; bus.flush = 1;
    #1;
    chk++; if ({bus.ex_stall, bus.wb_valid} !== 2'b00) $display("FAIL fe_done_flush got %b want 00", {bus.ex_stall, bus.wb_valid}); else pass++;
    next();
    drive_idle();
    #1;
    chk++; if (wb_cnt !== w0) $display("FAIL fe_no_wb got %0d want %0d", wb_cnt, w0); else pass++;
  endtask

  task automatic test_rd0_remu();
    int h0, w0;
    h0 = hs_cnt; w0 = wb_cnt;
    run_zero(OP_REMU, 32'd10, 32'd3, 5'd0, 32'd1);
    chk++; if (hs_cnt - h0 !== 1) $display("FAIL rd0_hs got %0d want 1", hs_cnt - h0); else pass++;
    chk++; if (wb_cnt !== w0) $display("FAIL rd0_no_wb got %0d want %0d", wb_cnt, w0); else pass++;
  endtask

  task automatic test_timeout();
    int w0;
    w0 = wb_cnt;
    issue(OP_MUL, 32'd9, 32'd9, 5'd7);
    next();
    bus.ex_valid = 0; bus.m_req_ready = 1;
    next();
    bus.m_req_ready = 0;
    for (int i = 0; i < TMO; i++) begin
      #1;
      chk++; if ({bus.ex_stall, bus.wb_valid, bus.timeout_err} !== 3'b100) $display("FAIL to_wait%0d got %b want 100", i, {bus.ex_stall, bus.wb_valid, bus.timeout_err}); else pass++;
      next();
    end
    #1;
    chk++; if ({bus.ex_stall, bus.wb_valid, bus.timeout_err} !== 3'b111) $display("FAIL to_fire got %b want 111", {bus.ex_stall, bus.wb_valid, bus.timeout_err}); else pass++;
    chk++; if ({bus.wb_rd, bus.wb_data} !== {5'd7, 32'hFFFF_FFFF}) $display("FAIL to_wb got %h want %h", {bus.wb_rd, bus.wb_data}, {5'd7, 32'hFFFF_FFFF}); else pass++;
    next();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk++; if ({bus.ex_stall, bus.wb_valid, bus.timeout_err} !== 3'b101) $display("FAIL to_drain%0d got %b want 101", i, {bus.ex_stall, bus.wb_valid, bus.timeout_err}); else pass++;
      next();
    end
    bus.m_rsp_valid = 1; bus.m_rsp_result = 32'd123;
    #1;
    chk++; if ({bus.ex_stall, bus.wb_valid, bus.timeout_err} !== 3'b101) $display("FAIL to_late_rsp got %b want 101", {bus.ex_stall, bus.wb_valid, bus.timeout_err}); else pass++;
    next();
    drive_idle();
    #1;
    chk++; if ({bus.ex_stall, bus.wb_valid, bus.timeout_err} !== 3'b001) $display("FAIL to_sticky got %b want 001", {bus.ex_stall, bus.wb_valid, bus.timeout_err}); else pass++;
    chk++; if (wb_cnt - w0 !== 1) $display("FAIL to_wb_count got %0d want 1", wb_cnt - w0); else pass++;
  endtask

  task automatic test_async_reset();
    issue(OP_MUL, 32'd8, 32'd8, 5'd2);
    next();
    bus.ex_valid = 0; bus.m_req_ready = 1;
    next();
    bus.m_req_ready = 0;
    #1;
    chk++; if (bus.ex_stall !== 1'b1) $display("FAIL ar_pre_stall got %b want 1", bus.ex_stall); else pass++;
    #1;
    rst_n = 0;
    #1;
    chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid, bus.timeout_err} !== 4'b0) $display("FAIL ar_flags got %b want 0000", {bus.ex_stall, bus.m_req_valid, bus.wb_valid, bus.timeout_err}); else pass++;
    chk++; if ({bus.m_op, bus.m_operand_a, bus.m_operand_b, bus.wb_rd, bus.wb_data} !== 104'b0) $display("FAIL ar_data got %h want 0", {bus.m_op, bus.m_operand_a, bus.m_operand_b, bus.wb_rd, bus.wb_data}); else pass++;
    #2;
    rst_n = 1;
    next();
    #1;
    chk++; if ({bus.ex_stall, bus.m_req_valid, bus.wb_valid, bus.timeout_err} !== 4'b0) $display("FAIL ar_idle got %b want 0000", {bus.ex_stall, bus.m_req_valid, bus.wb_valid, bus.timeout_err}); else pass++;
    run_zero(OP_MUL, 32'd6, 32'd7, 5'd5, 32'd42);
  endtask

  initial begin
    test_reset();
    test_zero_latency_mul();
    test_backpressure_div();
    test_flush_wait();
    test_flush_edges();
    test_rd0_remu();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
